// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining into the UART controller's trigger/done handshake
// Flags dropped pushes (overflow) and a controller that never reports tx_done (timeout_err).
module uart_tx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DONE_TIMEOUT = 100_000
) (
  input  logic                       sclk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       err_clr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       tx_trigger,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_done,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [31:0]   TO_LAST   = 32'(DONE_TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [0:0]    state;
  logic [31:0]   to_cnt;
  logic          push;
  logic          pop;
  logic          to_hit;

  assign full  = (level == LVL_DEPTH);
  assign empty = (level == '0);
  assign busy  = (state == ST_WAIT);

  // A full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign push   = wr_en && !full;
  assign pop    = (state == ST_IDLE) && (level != '0);
  assign to_hit = (state == ST_WAIT) && !tx_done && (DONE_TIMEOUT != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge sclk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      state       <= ST_IDLE;
      to_cnt      <= '0;
      tx_trigger  <= 1'b0;
      tx_byte     <= 8'hFF;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        tx_byte <= mem[rd_ptr];
      end

      if (push && !pop) begin
        level <= level + LVL_ONE;
      end else if (pop && !push) begin
        level <= level - LVL_ONE;
      end

      // New error events take priority over a simultaneous clear.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (to_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end

      tx_trigger <= pop;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            state  <= ST_WAIT;
            to_cnt <= '0;
          end
        end
        default: begin
          if (to_cnt != '1) begin
            to_cnt <= to_cnt + 32'd1;
          end
          // On timeout the byte is treated as sent; no retry.
          if (tx_done || to_hit) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
// Table-driven cycle vectors plus scripted corner cases, with a byte-order scoreboard on tx_trigger.
module tb_uart_tx_fifo;

  logic       sclk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       err_clr = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_trigger;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;
  logic       busy;
  logic       timeout_err;

  uart_tx_fifo #(.DEPTH(16), .DONE_TIMEOUT(50)) dut (
    .sclk(sclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .err_clr(err_clr),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .tx_trigger(tx_trigger), .tx_byte(tx_byte), .tx_done(tx_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 sclk = ~sclk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         trig_cyc = 0;
  int         n_trig = 0;
  logic [7:0] sb_q[$];
  logic       prev_trig = 1'b0;
  logic       prev_busy = 1'b0;
  bit         auto_done = 1'b0;
  int         done_dly = 20;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_done;
    logic [4:0] lvl;
    logic       trig;
    logic       busy;
    logic [7:0] byt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge sclk) cyc <= cyc + 1;

  // Scoreboard and trigger-spacing monitor.
  always @(negedge sclk) begin
    if (!rst && tx_trigger) begin
      n_trig++;
      trig_cyc = cyc;
      chk("trig_spacing", {30'd0, prev_trig, prev_busy}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_trigger", 32'd1, 32'd0);
      end else begin
        chk("sb_tx_byte", {24'd0, tx_byte}, {24'd0, sb_q.pop_front()});
      end
    end
    prev_trig = tx_trigger;
    prev_busy = busy;
  end

  // Stub controller: answers each trigger with tx_done after done_dly cycles.
  initial begin
    forever begin
      @(negedge sclk);
      if (auto_done && tx_trigger && !rst) begin
        repeat (done_dly - 1) @(negedge sclk);
        tx_done = 1'b1;
        @(negedge sclk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) sb_q.push_back(d);
    @(posedge sclk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    int tr0;
    bit seen_full;

    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 8'hFF};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5};
    tbl[2]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b1, 8'hA5};
    tbl[3]  = '{1'b1, 8'h7E, 1'b0, 5'd2, 1'b0, 1'b1, 8'hA5};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 8'hA5};
    tbl[5]  = '{1'b1, 8'h11, 1'b1, 5'd2, 1'b1, 1'b1, 8'h3C};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b1, 8'h3C};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 8'h3C};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b1, 8'h7E};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 8'h7E};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h11};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h11};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 8'h11};

    repeat (3) @(posedge sclk);
    #1;
    rst = 1'b0;

    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'hFF);
    chk("rst_trigger", {31'd0, tx_trigger}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      wr_en   = tbl[i].wr_en;
      wr_data = tbl[i].wr_data;
      tx_done = tbl[i].tx_done;
      if (tbl[i].wr_en) sb_q.push_back(tbl[i].wr_data);
      step();
      wr_en   = 1'b0;
      tx_done = 1'b0;
      chk($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, tbl[i].lvl});
      chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].lvl == 5'd0});
      chk($sformatf("vec%0d_trigger", i), {31'd0, tx_trigger}, {31'd0, tbl[i].trig});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("vec%0d_tx_byte", i), {24'd0, tx_byte}, {24'd0, tbl[i].byt});
    end

    // Single byte with a 20-cycle controller.
    auto_done = 1'b1;
    done_dly  = 20;
    push(8'h55, 1'b1);
    chk("one_trig_early", {31'd0, tx_trigger}, 32'd0);
    chk("one_level_after_push", {27'd0, level}, 32'd1);
    step();
    chk("one_trig", {31'd0, tx_trigger}, 32'd1);
    chk("one_byte", {24'd0, tx_byte}, 32'h55);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("one_busy_cycles", n, 32'd20);
    chk("one_empty_after", {31'd0, empty}, 32'd1);

    // Burst of 16 with a fast controller.
    done_dly  = 3;
    seen_full = 1'b0;
    tr0       = n_trig;
    for (int i = 1; i <= 16; i++) begin
      push(8'(i), 1'b1);
      if (full) seen_full = 1'b1;
    end
    n = 0;
    while ((!empty || busy) && n < 200) begin
      step();
      if (full) seen_full = 1'b1;
      n++;
    end
    chk("burst_drained", {31'd0, (!empty || busy)}, 32'd0);
    chk("burst_no_full", {31'd0, seen_full}, 32'd0);
    chk("burst_no_overflow", {31'd0, overflow}, 32'd0);
    chk("burst_trigger_count", n_trig - tr0, 32'd16);
    repeat (5) step();

    // Stalled controller: fill, overflow, clear, then time out.
    auto_done = 1'b0;
    push(8'h80, 1'b1);
    step();
    chk("stall_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) push(8'h81 + 8'(i), 1'b1);
    chk("stall_full", {31'd0, full}, 32'd1);
    chk("stall_level16", {27'd0, level}, 32'd16);
    chk("stall_no_overflow_yet", {31'd0, overflow}, 32'd0);
    err_clr = 1'b1;
    push(8'hEE, 1'b0);
    err_clr = 1'b0;
    chk("ovf_wins_over_clr", {31'd0, overflow}, 32'd1);
    chk("ovf_level_kept", {27'd0, level}, 32'd16);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    t0 = trig_cyc;
    n  = 0;
    while (!timeout_err && n < 100) begin
      @(negedge sclk);
      n++;
    end
    chk("timeout_seen", {31'd0, timeout_err}, 32'd1);
    chk("timeout_latency", cyc - t0, 32'd50);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    @(negedge sclk);
    chk("timeout_next_trig", {31'd0, tx_trigger}, 32'd1);
    #1;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("timeout_cleared", {31'd0, timeout_err}, 32'd0);

    rst = 1'b1;
    sb_q.delete();
    step();
    rst = 1'b0;
    chk("flush_level", {27'd0, level}, 32'd0);

    // Reset while waiting with 5 bytes queued.
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i), 1'b1);
    chk("rq_level5", {27'd0, level}, 32'd5);
    chk("rq_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    sb_q.delete();
    step();
    rst = 1'b0;
    chk("rq_level0", {27'd0, level}, 32'd0);
    chk("rq_empty", {31'd0, empty}, 32'd1);
    chk("rq_busy0", {31'd0, busy}, 32'd0);
    chk("rq_tx_byte", {24'd0, tx_byte}, 32'hFF);
    tr0 = n_trig;
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    repeat (5) step();
    chk("late_done_no_trig", n_trig - tr0, 32'd0);
    chk("late_done_idle", {31'd0, busy}, 32'd0);
    chk("sb_all_consumed", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO and transmit sequencer that sits directly upstream of the UART controller. Producer logic pushes bytes at any rate up to one per clock. The block drains them one at a time into the controller's `tx_trigger`/`tx_byte`/`tx_done` handshake, so multi-byte messages go out back-to-back without the producer tracking frame timing. It also flags overflow and a stalled controller.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DONE_TIMEOUT`, 100_000: max cycles to wait for `tx_done` after a trigger; 0 disables the timeout.
- `sclk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en` in 1: push `wr_data` this cycle.
- `wr_data` in 8: byte to push.
- `err_clr` in 1: clears `overflow` and `timeout_err`.
- `full` out 1: `level == DEPTH`.
- `empty` out 1: `level == 0`.
- `level` out $clog2(DEPTH+1): number of stored bytes.
- `overflow` out 1: sticky; a push was dropped.
- `tx_trigger` out 1: one-cycle pulse to the controller; registered.
- `tx_byte` out 8: byte for the controller; valid in the `tx_trigger` cycle and held until the next pop.
- `tx_done` in 1: one-cycle completion pulse from the controller.
- `busy` out 1: FSM not in IDLE.
- `timeout_err` out 1: sticky; `tx_done` was not seen within `DONE_TIMEOUT`.

## Operation
- Storage: `DEPTH`×8 register array.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
  - `level` is updated as +1 on push, −1 on pop, unchanged on both or neither.
- Push: accepted when `wr_en && !full`.
  - Data is written at `wr_ptr`, and `wr_ptr` increments.
  - `wr_en && full`: byte dropped, `overflow` ← 1, no other state changes.
  - A full FIFO rejects a push even if a pop happens in the same cycle.
- FSM states IDLE and WAIT:
  - IDLE, `level != 0`: pop. `tx_byte` ← `mem[rd_ptr]`, `rd_ptr`++, `tx_trigger` ← 1, timeout counter ← 0, go to WAIT.
  - IDLE, `level == 0`: stay; `tx_trigger` = 0.
  - WAIT: `tx_trigger` ← 0 and the timeout counter increments each cycle (saturating, 32-bit).
  - WAIT, `tx_done` = 1: go to IDLE.
  - WAIT, `DONE_TIMEOUT != 0` and counter == `DONE_TIMEOUT`−1 with no `tx_done`: `timeout_err` ← 1, go to IDLE. The byte counts as sent; it is not retried.
  - `tx_done` received in IDLE is ignored.
- Simultaneous push and pop in IDLE: both happen and `level` is unchanged.
- Pushing into an empty FIFO: IDLE sees `level` = 0 on the push edge, so the pop happens on the following edge.
- `err_clr` clears both sticky flags. If a new error event occurs in the same cycle as `err_clr`, the error wins (flag set).
- `busy` = (state == WAIT).
- Reset values: state IDLE, pointers 0, `level` 0, `empty` 1, `full` 0, `tx_trigger` 0, `tx_byte` 8'hFF, `busy` 0, `overflow` 0, `timeout_err` 0. Memory contents are don't-care.
- Reset mid-frame abandons the wait and discards all stored bytes. The controller finishes its current frame on its own; its `tx_done` then arrives in IDLE and is ignored.

## Timing
- `wr_en` at edge k into an empty FIFO:
  - `level` = 1 after edge k.
  - `tx_trigger` = 1 and `tx_byte` = data during the cycle after edge k+1.
  - `level` = 0 after edge k+1.
  - Latency is 2 cycles.
- `tx_done` at edge m: state is IDLE after edge m. The next `tx_trigger` is asserted after edge m+1 when `level` > 0. This gives 2 cycles from `tx_done` to the next trigger.
- `tx_trigger` is never high on two consecutive cycles and never high while `busy` was high on the prior cycle.
- `tx_byte` changes only on the pop edge, so it is stable for the entire WAIT period.
- `full`, `empty` and `level` reflect the state after the last edge. They are registered or purely derived from registered `level`.

## Test plan
- Reset, then push 8'h55 once with a stub controller giving `tx_done` 20 cycles after the trigger:
  - Before the push: `empty` = 1, `tx_byte` = 8'hFF.
  - After the push: one `tx_trigger` appears 2 cycles later with `tx_byte` = 8'h55.
  - `busy` stays high until `tx_done`, then `empty` = 1.
- Burst push 8'h01..8'h10 (16 bytes, `DEPTH` = 16) on consecutive cycles:
  - `full` is never seen because popping starts on the 2nd cycle; no `overflow`.
  - Exactly 16 triggers appear, carrying bytes in order 01..10.
- Stall the controller (no `tx_done`) and push 17 bytes while the first is in WAIT:
  - `full` = 1 at `level` 16.
  - The 17th push is dropped and `overflow` = 1.
  - `err_clr` → `overflow` = 0.
- `DONE_TIMEOUT` = 50, never send `tx_done`:
  - `timeout_err` = 1 exactly 50 cycles after the trigger.
  - The next queued byte is triggered 1 cycle after return to IDLE.
- Assert `rst` during WAIT with 5 bytes queued:
  - Next cycle: `level` = 0, `busy` = 0, `tx_byte` = 8'hFF.
  - A late `tx_done` produces no trigger.
- Connect a real `uart_ctrler` (50 MHz, 115200 baud) and push "Hi\r\n":
  - The serial line shows 4 frames back-to-back with correct LSB-first bits.
